// File: rtl/lcd_text_writer_if.sv
// lcd_text_writer_if -- bundles the text-source handshake and the HD44780 bus.
//   index      : slot requested from the text source (writer -> source)
//   char_in    : ASCII byte for that slot, 1-cycle registered latency (source -> writer)
//   lcd_e      : enable strobe
//   lcd_rs     : register select (0 command, 1 data)
//   lcd_rw     : read/write select, always write
//   lcd_data   : 8-bit LCD data bus
//   init_done  : init command sequence finished
//   frame_done : one-cycle pulse after slot 31 has been written
// Modport master is the writer side; modport slave is the source/LCD side.
interface lcd_text_writer_if;
    logic [4:0] index;
    logic [7:0] char_in;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       init_done;
    logic       frame_done;

    modport master (
        output index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done,
        input  char_in
    );

    modport slave (
        input  index, lcd_e, lcd_rs, lcd_rw, lcd_data, init_done, frame_done,
        output char_in
    );
endinterface

// File: rtl/lcd_text_writer.sv
// lcd_text_writer -- drives an HD44780 in 8-bit write-only mode: power-up delay,
// init commands 0x38/0x0C/0x06/0x01, then refreshes a 2x16 text frame forever,
// fetching each character from an external source addressed by index.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : lcd_text_writer_if.master (index/char_in source handshake + LCD bus)
// Optional feature: define LCD_NONPRINT_BLANK_EN to replace sampled characters
// outside 0x20..0x7E with a blank (0x20); undefined writes char_in unmodified.
// Every bus write is: 1 setup cycle, E_PULSE_CYC cycles with lcd_e high,
// 1 hold cycle, then CMD_WAIT_CYC (CLEAR_WAIT_CYC after command 0x01) idle cycles.
module lcd_text_writer #(
    parameter int POWERUP_CYC    = 20,
    parameter int E_PULSE_CYC    = 4,
    parameter int CMD_WAIT_CYC   = 8,
    parameter int CLEAR_WAIT_CYC = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    lcd_text_writer_if.master      bus
);
    // One shared counter serves power-up, pulse, wait and fetch timing, so it
    // must hold the largest of the parameters.
    localparam int MAX_PE  = (POWERUP_CYC > E_PULSE_CYC) ? POWERUP_CYC : E_PULSE_CYC;
    localparam int MAX_WT  = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int CNT_MAX = (MAX_PE > MAX_WT) ? MAX_PE : MAX_WT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] PWR_LAST  = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] E_LAST    = CW'(E_PULSE_CYC - 1);
    localparam logic [CW-1:0] CMD_LAST  = CW'(CMD_WAIT_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST  = CW'(CLEAR_WAIT_CYC - 1);
    localparam logic [CW-1:0] FETCH_END = CW'(1);

    typedef enum logic [2:0] {
        PWRUP      = 3'd0,
        INIT       = 3'd1,
        LINE_ADDR  = 3'd2,
        FETCH      = 3'd3,
        WRITE_CHAR = 3'd4,
        NEXT       = 3'd5
    } state_t;

    // Sub-phase of a single bus write, used inside INIT, LINE_ADDR and WRITE_CHAR.
    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_PULSE = 2'd1,
        PH_HOLD  = 2'd2,
        PH_WAIT  = 2'd3
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic [4:0]    index_q, index_d;
    logic          lcd_e_q, lcd_e_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;

    logic          writing_s;
    logic [CW-1:0] wait_last_s;
    logic          write_done_s;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] cmd;
        case (idx)
            2'd0:    cmd = 8'h38;
            2'd1:    cmd = 8'h0C;
            2'd2:    cmd = 8'h06;
            2'd3:    cmd = 8'h01;
            default: cmd = 8'h01;
        endcase
        return cmd;
    endfunction

    function automatic logic [7:0] char_filter(input logic [7:0] c);
`ifdef LCD_NONPRINT_BLANK_EN
        logic [7:0] r;
        if ((c < 8'h20) || (c > 8'h7E)) begin
            r = 8'h20;
        end else begin
            r = c;
        end
        return r;
`else
        return c;
`endif
    endfunction

    // Write-phase status: the clear command (rs=0, 0x01) needs the long wait.
    always_comb begin
        writing_s    = (state_q == INIT) || (state_q == LINE_ADDR) || (state_q == WRITE_CHAR);
        wait_last_s  = (!lcd_rs_q && (lcd_data_q == 8'h01)) ? CLR_LAST : CMD_LAST;
        write_done_s = (phase_q == PH_WAIT) && (cnt_q == wait_last_s);
    end

    // Next-state logic: the write sequencer first, then the state machine, which
    // overrides the sequencer when it launches a new write. Data and rs are only
    // ever loaded together with the move into PH_SETUP.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        init_idx_d   = init_idx_q;
        index_d      = index_q;
        lcd_e_d      = lcd_e_q;
        lcd_rs_d     = lcd_rs_q;
        lcd_data_d   = lcd_data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;

        if (writing_s) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_PULSE;
                    lcd_e_d = 1'b1;
                    cnt_d   = '0;
                end
                PH_PULSE: begin
                    if (cnt_q == E_LAST) begin
                        phase_d = PH_HOLD;
                        lcd_e_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PH_HOLD: begin
                    phase_d = PH_WAIT;
                    cnt_d   = '0;
                end
                PH_WAIT: begin
                    if (cnt_q != wait_last_s) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: begin
                    phase_d = PH_SETUP;
                    lcd_e_d = 1'b0;
                end
            endcase
        end else begin
            lcd_e_d = 1'b0;
        end

        case (state_q)
            PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d    = INIT;
                    init_idx_d = 2'd0;
                    phase_d    = PH_SETUP;
                    cnt_d      = '0;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            INIT: begin
                if (write_done_s) begin
                    phase_d  = PH_SETUP;
                    cnt_d    = '0;
                    lcd_rs_d = 1'b0;
                    if (init_idx_q == 2'd3) begin
                        init_done_d = 1'b1;
                        state_d     = LINE_ADDR;
                        lcd_data_d  = 8'h80;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        lcd_data_d = init_cmd(init_idx_q + 2'd1);
                    end
                end else begin
                    state_d = state_q;
                end
            end
            LINE_ADDR: begin
                if (write_done_s) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            FETCH: begin
                // index has been stable two cycles; the source's registered
                // output now reflects it, so capture it into the bus here.
                if (cnt_q == FETCH_END) begin
                    state_d    = WRITE_CHAR;
                    phase_d    = PH_SETUP;
                    cnt_d      = '0;
                    lcd_rs_d   = 1'b1;
                    lcd_data_d = char_filter(bus.char_in);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WRITE_CHAR: begin
                if (write_done_s) begin
                    state_d = NEXT;
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            NEXT: begin
                cnt_d = '0;
                if (index_q == 5'd31) begin
                    index_d      = 5'd0;
                    frame_done_d = 1'b1;
                    state_d      = LINE_ADDR;
                    phase_d      = PH_SETUP;
                    lcd_rs_d     = 1'b0;
                    lcd_data_d   = 8'h80;
                end else if (index_q == 5'd15) begin
                    index_d    = 5'd16;
                    state_d    = LINE_ADDR;
                    phase_d    = PH_SETUP;
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = 8'hC0;
                end else begin
                    index_d = index_q + 5'd1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = PWRUP;
                phase_d = PH_SETUP;
                cnt_d   = '0;
                lcd_e_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops lcd_e immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= PWRUP;
            phase_q      <= PH_SETUP;
            cnt_q        <= '0;
            init_idx_q   <= 2'd0;
            index_q      <= 5'd0;
            lcd_e_q      <= 1'b0;
            lcd_rs_q     <= 1'b0;
            lcd_data_q   <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            init_idx_q   <= init_idx_d;
            index_q      <= index_d;
            lcd_e_q      <= lcd_e_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_data_q   <= lcd_data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.index      = index_q;
    assign bus.lcd_e      = lcd_e_q;
    assign bus.lcd_rs     = lcd_rs_q;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_data   = lcd_data_q;
    assign bus.init_done  = init_done_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: doc/lcd_text_writer.md
LCD_TEXT_WRITER -- requirements
Module: lcd_text_writer

Interface
REQ-001 The block SHALL expose parameter POWERUP_CYC, default 20, giving idle cycles after reset before the first command.
REQ-002 The block SHALL expose parameter E_PULSE_CYC, default 4, giving the number of cycles lcd_e is held high per bus write.
REQ-003 The block SHALL expose parameter CMD_WAIT_CYC, default 8, giving idle cycles after each command or data write.
REQ-004 The block SHALL expose parameter CLEAR_WAIT_CYC, default 32, giving idle cycles after the clear command (0x01).
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 char_in  input  8  ASCII code from the text source for the current index.
REQ-008 index  output  5  character slot requested from the text source (0-15 line 1, 16-31 line 2).
REQ-009 lcd_e  output  1  HD44780 enable strobe.
REQ-010 lcd_rs  output  1  register select: 0 = command, 1 = data.
REQ-011 lcd_rw  output  1  read/write select; SHALL be tied to 0 (write only).
REQ-012 lcd_data  output  8  8-bit LCD data bus.
REQ-013 init_done  output  1  high once the init command sequence has completed; stays high until reset.
REQ-014 frame_done  output  1  one-cycle pulse after slot 31 has been written.

Function
REQ-015 Each bus write SHALL take 1 setup cycle (lcd_rs and lcd_data valid, lcd_e=0), then E_PULSE_CYC cycles with lcd_e=1, then 1 hold cycle (lcd_e=0, data unchanged), then a wait of CMD_WAIT_CYC cycles (CLEAR_WAIT_CYC for 0x01).
REQ-016 lcd_rs and lcd_data SHALL change only in the setup cycle of a write.
REQ-017 FSM states SHALL be PWRUP, INIT, LINE_ADDR, FETCH, WRITE_CHAR and NEXT.
REQ-018 PWRUP: wait POWERUP_CYC cycles, then go to INIT.
REQ-019 INIT: issue commands 0x38, 0x0C, 0x06, 0x01 in order (rs=0); after the 0x01 wait, set init_done and go to LINE_ADDR.
REQ-020 LINE_ADDR: issue 0x80 when index=0, or 0xC0 when index=16, then go to FETCH.
REQ-021 FETCH: hold index stable for exactly 2 cycles and sample char_in at the end of the second cycle; this covers the source's 1-cycle registered latency.
REQ-022 WRITE_CHAR: write the sampled byte with rs=1.
REQ-023 NEXT, index 0-14 or 16-30: increment index and go to FETCH.
REQ-024 NEXT, index 15: set index to 16 and go to LINE_ADDR.
REQ-025 NEXT, index 31: pulse frame_done, wrap index to 0 and go to LINE_ADDR; refresh SHALL repeat indefinitely without re-running INIT.
REQ-026 Wait counters SHALL be wide enough for the largest parameter and SHALL NOT wrap early.
REQ-027 A char_in change outside FETCH SHALL NOT affect the byte being written.

Reset
REQ-028 While rst=0, outputs SHALL be index=0, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, init_done=0, frame_done=0; the FSM SHALL be in PWRUP with counters cleared.
REQ-029 Reset asserted mid-write SHALL drop lcd_e immediately; after release the full PWRUP/INIT sequence SHALL restart.

Configuration
REQ-030 Macro LCD_NONPRINT_BLANK_EN defined: a sampled char_in outside 0x20-0x7E SHALL be written as 0x20.
REQ-031 Macro LCD_NONPRINT_BLANK_EN undefined: char_in SHALL be written unmodified.

Verification
REQ-032 Reset release, POWERUP_CYC=20 -> first lcd_e rise at cycle 22 with lcd_data=0x38, rs=0; then 0x0C, 0x06, 0x01; init_done rises after the 32-cycle clear wait.
REQ-033 Source model with 1-cycle registered latency returning 0x41+index -> 0x80, 'A'..'P', 0xC0, 'Q'..'`' written in order; frame_done pulses once; next frame restarts with 0x80.
REQ-034 Every write -> lcd_e high exactly 4 cycles; lcd_data stable from setup through the hold cycle; lcd_rw always 0.
REQ-035 char_in=0x07 at slot 5 -> 0x20 written with LCD_NONPRINT_BLANK_EN defined; 0x07 written without it.
REQ-036 rst pulsed low during the lcd_e-high phase of slot 20 -> lcd_e=0 and init_done=0 asynchronously; after release, a full init sequence precedes 0x80.
